// File: rtl/solve_arbiter.sv
// Round-robin arbiter that shares one triangular solver among NREQ requesters.
// It latches the granted problem, issues one solver pulse, waits for the result
// with a timeout, and returns the result tagged with the requester index.
// Real values are carried as raw 64-bit IEEE-754 patterns and are never modified.
module solve_arbiter #(
  parameter int unsigned N       = 3,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NREQ-1:0]                       req_valid,
  output logic [NREQ-1:0]                       req_ready,
  input  logic [NREQ-1:0][N-1:0][N-1:0][63:0]   req_M,
  input  logic [NREQ-1:0][N-1:0][63:0]          req_b,
  output logic                                  slv_in_valid,
  output logic [N-1:0][N-1:0][63:0]             slv_M,
  output logic [N-1:0][63:0]                    slv_b,
  input  logic                                  slv_out_valid,
  input  logic [N-1:0][63:0]                    slv_x,
  output logic                                  resp_valid,
  input  logic                                  resp_ready,
  output logic [$clog2(NREQ)-1:0]               resp_id,
  output logic [N-1:0][63:0]                    resp_x,
  output logic                                  err
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   cur_id;
  logic [WW-1:0]   wait_cnt;
  logic            gnt_found;
  logic [IW-1:0]   gnt_idx;
  logic [IW-1:0]   cand_id;
  int unsigned     cand;
  logic            grant;
  logic            capture;

  // Pick the first pending requester after the round-robin pointer.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_id   = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand    = (32'(rr_ptr) + i) % NREQ;
      cand_id = IW'(cand);
      if (!gnt_found && req_valid[cand_id]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_id;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode; req_ready is held low while reset is asserted.
  always_comb begin
    state_nxt    = state;
    req_ready    = '0;
    slv_in_valid = 1'b0;
    resp_valid   = 1'b0;
    err          = 1'b0;
    grant        = 1'b0;
    capture      = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_found) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
          if (!rst) begin
            req_ready[gnt_idx] = 1'b1;
          end
        end
      end
      ISSUE: begin
        slv_in_valid = 1'b1;
        state_nxt    = WAIT;
      end
      WAIT: begin
        if (slv_out_valid) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
          err       = 1'b1;
          state_nxt = IDLE;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant bookkeeping and latched copy of the granted problem.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= IW'(NREQ - 1);
      cur_id <= '0;
      slv_M  <= '0;
      slv_b  <= '0;
    end else if (grant) begin
      rr_ptr <= gnt_idx;
      cur_id <= gnt_idx;
      slv_M  <= req_M[gnt_idx];
      slv_b  <= req_b[gnt_idx];
    end
  end

  // Solver wait counter: cleared on issue, counts every WAIT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == ISSUE) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + WW'(1);
    end
  end

  // Result capture; held until the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_x  <= '0;
      resp_id <= '0;
    end else if (capture) begin
      resp_x  <= slv_x;
      resp_id <= cur_id;
    end
  end

endmodule

// File: tb/tb_solve_arbiter.sv
// Directed bench for solve_arbiter with a behavioural 1-cycle solver stub and
// a scoreboard of expected (id, x) results pushed at grant time.
module tb_solve_arbiter;

  localparam int unsigned N       = 3;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned TIMEOUT = 16;

  typedef logic [N-1:0][N-1:0][63:0] mat_t;
  typedef logic [N-1:0][63:0]        vec_t;
  typedef logic [575:0]              big_t;
  typedef struct packed {
    logic [1:0] id;
    vec_t       x;
  } exp_t;

  logic                         clk;
  logic                         rst;
  logic [NREQ-1:0]              req_valid;
  logic [NREQ-1:0]              req_ready;
  logic [NREQ-1:0][N-1:0][N-1:0][63:0] req_M;
  logic [NREQ-1:0][N-1:0][63:0] req_b;
  logic                         slv_in_valid;
  mat_t                         slv_M;
  vec_t                         slv_b;
  logic                         slv_out_valid;
  vec_t                         slv_x;
  logic                         resp_valid;
  logic                         resp_ready;
  logic [1:0]                   resp_id;
  vec_t                         resp_x;
  logic                         err;

  logic stub_en;
  int   checks;
  int   passed;
  int   cyc;
  int   err_cnt;
  int   err_cyc;
  exp_t sb[$];
  int   grants[$];
  int   gcyc[$];

  solve_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_M(req_M), .req_b(req_b),
    .slv_in_valid(slv_in_valid), .slv_M(slv_M), .slv_b(slv_b),
    .slv_out_valid(slv_out_valid), .slv_x(slv_x),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_x(resp_x), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference upper-triangular back-substitution.
  function automatic vec_t solve_ref(input mat_t m, input vec_t b);
    real  x[N];
    real  s;
    vec_t r;
    for (int i = N - 1; i >= 0; i--) begin
      s = $bitstoreal(b[i]);
      for (int j = i + 1; j < N; j++) s = s - $bitstoreal(m[i][j]) * x[j];
      x[i] = s / $bitstoreal(m[i][i]);
    end
    for (int i = 0; i < N; i++) r[i] = $realtobits(x[i]);
    return r;
  endfunction

  function automatic mat_t mkm(input real a00, a01, a02, a11, a12, a22);
    mat_t m;
    m       = '0;
    m[0][0] = $realtobits(a00); m[0][1] = $realtobits(a01); m[0][2] = $realtobits(a02);
    m[1][1] = $realtobits(a11); m[1][2] = $realtobits(a12); m[2][2] = $realtobits(a22);
    m[1][0] = $realtobits(0.0); m[2][0] = $realtobits(0.0); m[2][1] = $realtobits(0.0);
    return m;
  endfunction

  function automatic vec_t mkv(input real b0, b1, b2);
    vec_t v;
    v[0] = $realtobits(b0); v[1] = $realtobits(b1); v[2] = $realtobits(b2);
    return v;
  endfunction

  task automatic chk(input string tag, input big_t obs, input big_t expv);
    checks = checks + 1;
    assert (obs === expv) passed = passed + 1;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string tag, input int limit);
    int found;
    found = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      #1;
      if (|req_ready) begin
        found = 1;
        break;
      end
    end
    chk(tag, big_t'(found), big_t'(1));
  endtask

  task automatic wait_resp(input string tag, input int limit);
    int found;
    found = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      #1;
      if (resp_valid) begin
        found = 1;
        break;
      end
    end
    chk(tag, big_t'(found), big_t'(1));
  endtask

  task automatic wait_drain(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) break;
    end
    chk(tag, big_t'(sb.size()), big_t'(0));
  endtask

  // Solver stub: registered result one cycle after in_valid, can be muted.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      slv_out_valid <= 1'b0;
      slv_x         <= '0;
    end else begin
      slv_out_valid <= stub_en & slv_in_valid;
      if (slv_in_valid) slv_x <= solve_ref(slv_M, slv_b);
    end
  end

  // Scoreboard: push on grant, compare on response handshake, drop on error.
  always @(negedge clk) begin
    int   gid;
    exp_t e;
    if (rst) begin
      sb.delete();
    end else begin
      if (|req_ready) begin
        gid = 0;
        for (int k = 0; k < NREQ; k++) if (req_ready[k]) gid = k;
        chk("req_ready_onehot", big_t'($onehot(req_ready)), big_t'(1));
        grants.push_back(gid);
        gcyc.push_back(cyc);
        e.id = 2'(gid);
        e.x  = solve_ref(req_M[gid], req_b[gid]);
        sb.push_back(e);
      end
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_resp", big_t'(1), big_t'(0));
        end else begin
          e = sb.pop_front();
          chk("sb_resp_id", big_t'(resp_id), big_t'(e.id));
          chk("sb_resp_x", big_t'(resp_x), big_t'(e.x));
        end
      end
      if (err) begin
        err_cnt = err_cnt + 1;
        err_cyc = cyc;
        if (sb.size() > 0) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int    c0;
    int    issue_cyc;
    int    seen;
    vec_t  rx;
    logic [1:0] rid;
    mat_t  m_orig;
    vec_t  b_std;
    int    exp_order[5];

    checks = 0; passed = 0; cyc = 0; err_cnt = 0; err_cyc = 0;
    rst = 1'b1; req_valid = '0; resp_ready = 1'b1; stub_en = 1'b1;
    b_std = mkv(9.0, 14.0, 10.0);
    for (int k = 0; k < NREQ; k++) begin
      req_M[k] = mkm(2.0 + k, 1.0, 1.0, 4.0 + k, 2.0, 5.0 + k);
      req_b[k] = b_std;
    end

    // Reset state
    @(negedge clk);
    chk("rst_req_ready", big_t'(req_ready), big_t'(0));
    chk("rst_outputs", big_t'({slv_in_valid, resp_valid, err, resp_id}), big_t'(0));
    chk("rst_slv_M", big_t'(slv_M), big_t'(0));
    chk("rst_slv_b_resp_x", big_t'({slv_b, resp_x}), big_t'(0));
    drive_edge();
    rst = 1'b0;
    drive_edge();

    // 1. single request from requester 0
    req_valid = 4'b0001;
    c0 = cyc;
    @(negedge clk);
    chk("t1_req_ready", big_t'(req_ready), big_t'(4'b0001));
    drive_edge();
    req_valid = '0;
    @(negedge clk);
    chk("t1_issue", big_t'(slv_in_valid), big_t'(1));
    chk("t1_slv_M", big_t'(slv_M), big_t'(mkm(2.0, 1.0, 1.0, 4.0, 2.0, 5.0)));
    drive_edge();
    @(negedge clk);
    chk("t1_wait_no_issue", big_t'({slv_in_valid, resp_valid}), big_t'(0));
    drive_edge();
    @(negedge clk);
    chk("t1_resp_valid", big_t'(resp_valid), big_t'(1));
    chk("t1_latency", big_t'(cyc - c0), big_t'(3));
    chk("t1_resp_id", big_t'(resp_id), big_t'(0));
    chk("t1_resp_x", big_t'(resp_x), big_t'(mkv(2.25, 2.5, 2.0)));
    drive_edge();
    @(negedge clk);
    chk("t1_resp_fall", big_t'(resp_valid), big_t'(0));
    wait_drain("t1_drain", 5);

    // 2. fairness with all requesters valid (pointer reset first)
    drive_edge();
    rst = 1'b1;
    drive_edge();
    rst = 1'b0;
    grants.delete();
    gcyc.delete();
    drive_edge();
    req_valid = 4'b1111;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (grants.size() >= 5) break;
    end
    drive_edge();
    req_valid = '0;
    chk("t2_grant_count", big_t'(grants.size()), big_t'(5));
    wait_drain("t2_drain", 20);
    exp_order = '{0, 1, 2, 3, 0};
    if (grants.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk($sformatf("t2_order%0d", i), big_t'(grants[i]), big_t'(exp_order[i]));
      chk("t2_period", big_t'(gcyc[4] - gcyc[0]), big_t'(16));
    end

    // 3. backpressure on the response
    drive_edge();
    resp_ready = 1'b0;
    req_valid  = 4'b0110;
    wait_grant("t3_grant", 5);
    chk("t3_req_ready", big_t'(req_ready), big_t'(4'b0010));
    drive_edge();
    req_valid = 4'b0100;
    wait_resp("t3_resp", 10);
    rx  = resp_x;
    rid = resp_id;
    chk("t3_rid", big_t'(rid), big_t'(1));
    chk("t3_rx", big_t'(rx), big_t'(solve_ref(mkm(3.0, 1.0, 1.0, 5.0, 2.0, 6.0), b_std)));
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("t3_hold_valid%0d", i), big_t'(resp_valid), big_t'(1));
      chk($sformatf("t3_hold_x%0d", i), big_t'(resp_x), big_t'(rx));
      chk($sformatf("t3_hold_id%0d", i), big_t'(resp_id), big_t'(rid));
      chk($sformatf("t3_no_grant%0d", i), big_t'(req_ready), big_t'(0));
    end
    drive_edge();
    resp_ready = 1'b1;
    @(negedge clk);
    chk("t3_handshake", big_t'(resp_valid), big_t'(1));
    drive_edge();
    @(negedge clk);
    chk("t3_idle_grant", big_t'(req_ready), big_t'(4'b0100));
    drive_edge();
    req_valid = '0;
    wait_drain("t3_drain", 10);

    // 4. solver timeout
    drive_edge();
    stub_en   = 1'b0;
    err_cnt   = 0;
    req_valid = 4'b1000;
    @(negedge clk);
    chk("t4_req_ready", big_t'(req_ready), big_t'(4'b1000));
    drive_edge();
    req_valid = '0;
    @(negedge clk);
    chk("t4_issue", big_t'(slv_in_valid), big_t'(1));
    issue_cyc = cyc;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (resp_valid) seen = 1;
    end
    chk("t4_err_count", big_t'(err_cnt), big_t'(1));
    chk("t4_err_time", big_t'(err_cyc - issue_cyc), big_t'(TIMEOUT));
    chk("t4_no_resp", big_t'(seen), big_t'(0));
    chk("t4_sb_empty", big_t'(sb.size()), big_t'(0));
    drive_edge();
    stub_en   = 1'b1;
    req_valid = 4'b0001;
    @(negedge clk);
    chk("t4_next_grant", big_t'(req_ready), big_t'(4'b0001));
    drive_edge();
    req_valid = '0;
    wait_drain("t4_drain", 10);

    // 5. reset during WAIT
    drive_edge();
    stub_en   = 1'b0;
    req_valid = 4'b0100;
    @(negedge clk);
    chk("t5_req_ready", big_t'(req_ready), big_t'(4'b0100));
    drive_edge();
    req_valid = '0;
    drive_edge();
    drive_edge();
    rst = 1'b1;
    #1;
    chk("t5_rst_ctrl", big_t'({req_ready, slv_in_valid, resp_valid, err, resp_id}), big_t'(0));
    chk("t5_rst_slv_M", big_t'(slv_M), big_t'(0));
    chk("t5_rst_vecs", big_t'({slv_b, resp_x}), big_t'(0));
    drive_edge();
    rst     = 1'b0;
    stub_en = 1'b1;
    seen    = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (resp_valid) seen = 1;
    end
    chk("t5_no_resp", big_t'(seen), big_t'(0));
    drive_edge();
    req_valid = 4'b1010;
    @(negedge clk);
    chk("t5_ptr_reset", big_t'(req_ready), big_t'(4'b0010));
    drive_edge();
    req_valid = '0;
    wait_drain("t5_drain", 10);

    // 6. requester changes its matrix after being granted
    drive_edge();
    m_orig    = mkm(4.0, 1.0, 1.0, 6.0, 2.0, 7.0);
    req_M[2]  = m_orig;
    req_valid = 4'b0100;
    @(negedge clk);
    chk("t6_req_ready", big_t'(req_ready), big_t'(4'b0100));
    drive_edge();
    req_valid = '0;
    req_M[2]  = mkm(1.0, 3.0, 3.0, 1.0, 3.0, 1.0);
    @(negedge clk);
    chk("t6_slv_M_latched", big_t'(slv_M), big_t'(m_orig));
    wait_resp("t6_resp", 10);
    chk("t6_resp_x", big_t'(resp_x), big_t'(solve_ref(m_orig, b_std)));
    wait_drain("t6_drain", 10);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
